// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single byte-wide synchronous RAM port between instruction fetch
// (IF) and the MEM stage. One requester is granted at a time. Each 1/2/4-byte
// access is split into byte-serial RAM cycles. Read bytes are assembled
// little-endian, write bytes are driven in order, and a one-cycle done pulse
// goes back to the winning requester.
//
// Optional feature (compile-time macro):
//   MEM_ARB_RR_EN  round-robin arbitration between IF and MEM. When undefined,
//                  MEM always has priority over IF.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-low reset
//   rdy        global enable; 0 freezes all state and suppresses ram_wr
//   if_req     fetch request, held until if_done
//   if_addr    fetch byte address (always a 4-byte access)
//   if_flush   abort an in-flight fetch (branch redirect)
//   if_data    fetched instruction, held until the next fetch completes
//   if_done    one-cycle fetch completion pulse
//   mem_req    load/store request, held until mem_done
//   mem_we     1 = store, 0 = load
//   mem_addr   load/store base byte address
//   mem_size   00 byte, 01 half, 10/11 word
//   mem_wdata  store data, byte 0 = bits 7:0
//   mem_rdata  zero-extended load data, held until the next load completes
//   mem_done   one-cycle load/store completion pulse
//   ram_a      RAM byte address
//   ram_wr     RAM write strobe
//   ram_dout   RAM write byte
//   ram_din    RAM read byte, valid one cycle after its address
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  // Index of the last byte of an access (byte count minus one).
  function automatic logic [1:0] size_to_last(input logic [1:0] size);
    case (size)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          last_q, last_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [23:0]         acc_q, acc_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic                ram_wr_q, ram_wr_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
`ifdef MEM_ARB_RR_EN
  owner_t              last_owner_q, last_owner_d;
`endif

  logic                if_ok;
  logic                pick_mem;
  logic                pick_if;
  logic [2:0]          cnt_nxt;
  logic [31:0]         rd_result;

  // Fetch is never granted in a cycle that carries a redirect.
  assign if_ok = if_req && !if_flush;

  always_comb begin
`ifdef MEM_ARB_RR_EN
    // Contested grant goes to whoever did not own the port last.
    if (mem_req && if_ok) pick_mem = (last_owner_q == OWN_IF);
    else                  pick_mem = mem_req;
`else
    pick_mem = mem_req;
`endif
    pick_if = if_ok && !pick_mem;
  end

  assign cnt_nxt = cnt_q + 3'd1;

  // Final read byte arrives on ram_din in the tail cycle; earlier bytes are in acc_q.
  always_comb begin
    case (last_q)
      2'd0:    rd_result = {24'h0, ram_din};
      2'd1:    rd_result = {16'h0, ram_din, acc_q[7:0]};
      default: rd_result = {ram_din, acc_q};
    endcase
  end

  // NOTE: every _d starts from its _q value (or a pulse default) before any
  // branch, so no path through this block leaves a signal unassigned and no
  // latch is inferred.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    last_d      = last_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    ram_a_d     = ram_a_q;
    ram_wr_d    = ram_wr_q;
    ram_dout_d  = ram_dout_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif

    if (rdy) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          ram_a_d    = '0;
          ram_wr_d   = 1'b0;
          ram_dout_d = 8'h0;
          if (pick_mem) begin
            state_d    = BUSY;
            owner_d    = OWN_MEM;
            base_d     = mem_addr;
            last_d     = size_to_last(mem_size);
            we_d       = mem_we;
            wdata_d    = mem_wdata;
            cnt_d      = 3'd0;
            ram_a_d    = mem_addr;
            ram_wr_d   = mem_we;
            ram_dout_d = mem_wdata[7:0];
`ifdef MEM_ARB_RR_EN
            last_owner_d = OWN_MEM;
`endif
          end else if (pick_if) begin
            state_d    = BUSY;
            owner_d    = OWN_IF;
            base_d     = if_addr;
            last_d     = 2'd3;
            we_d       = 1'b0;
            wdata_d    = 32'h0;
            cnt_d      = 3'd0;
            ram_a_d    = if_addr;
`ifdef MEM_ARB_RR_EN
            last_owner_d = OWN_IF;
`endif
          end
        end

        BUSY: begin
          if (owner_q == OWN_IF && if_flush) begin
            // Redirect abandons the fetch; if_data keeps its old value.
            state_d    = IDLE;
            cnt_d      = 3'd0;
            ram_a_d    = '0;
            ram_wr_d   = 1'b0;
            ram_dout_d = 8'h0;
          end else begin
            // cnt_q = k: byte k-1 addressed last cycle is on ram_din now.
            if (!we_q) begin
              case (cnt_q)
                3'd1:    acc_d[7:0]   = ram_din;
                3'd2:    acc_d[15:8]  = ram_din;
                3'd3:    acc_d[23:16] = ram_din;
                default: ;
              endcase
            end

            if (we_q && cnt_q == {1'b0, last_q}) begin
              state_d    = DONE;
              mem_done_d = 1'b1;
              ram_a_d    = '0;
              ram_wr_d   = 1'b0;
              ram_dout_d = 8'h0;
            end else if (!we_q && cnt_q == ({1'b0, last_q} + 3'd1)) begin
              state_d    = DONE;
              ram_a_d    = '0;
              ram_wr_d   = 1'b0;
              ram_dout_d = 8'h0;
              if (owner_q == OWN_IF) begin
                if_data_d = rd_result;
                if_done_d = 1'b1;
              end else begin
                mem_rdata_d = rd_result;
                mem_done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_nxt;
              if (cnt_q < {1'b0, last_q}) begin
                ram_a_d    = base_q + ADDR_W'(cnt_nxt);
                ram_wr_d   = we_q;
                ram_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
              end else begin
                // Read tail: address held so the last byte can be captured.
                ram_wr_d   = 1'b0;
                ram_dout_d = 8'h0;
              end
            end
          end
        end

        DONE: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      base_q      <= '0;
      last_q      <= 2'd0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      cnt_q       <= 3'd0;
      acc_q       <= 24'h0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      last_q      <= last_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign if_data   = if_data_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  // Stalled cycles and the reset edge itself must never commit a RAM byte.
  assign ram_wr    = ram_wr_q && rdy && rst;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares the single byte-wide synchronous RAM port between the instruction-fetch path (pc_reg/if_id side) and the MEM stage (loads/stores). It grants one requester at a time and splits each 1/2/4-byte access into byte-serial RAM cycles. It assembles little-endian read data, drives write bytes, and returns a one-cycle done pulse to the winning requester. It sits between the pipeline and the RAM port at the cpu top level.

## Interface
- ADDR_W, 32, width of all byte addresses
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- rdy  in  1  global enable; 0 freezes all state
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch byte address (word access)
- if_flush  in  1  abort in-flight fetch (branch redirect)
- if_data  out  32  fetched instruction
- if_done  out  1  one-cycle fetch completion pulse
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  load/store base byte address
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_wdata  in  32  store data, byte 0 = bits 7:0
- mem_rdata  out  32  load data, zero-extended; MEM stage sign-extends
- mem_done  out  1  one-cycle load/store completion pulse
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid one cycle after its address

## Operation
- States: IDLE, BUSY, DONE. Internal: owner (IF/MEM), latched base/size/we/wdata, byte counter cnt, last_owner.
- IDLE:
  - If mem_req or if_req is sampled (and no flush applies to IF): latch the winner's request, cnt←0, go to BUSY.
  - Default priority: MEM over IF.
  - if_req is not granted in a cycle where if_flush=1.
- BUSY, length N = 1/2/4 bytes:
  - Drive cycles k = 0..N-1: ram_a = base+k (mod 2^ADDR_W), ram_wr = we, ram_dout = wdata byte k.
  - Reads: byte k is captured from ram_din in cycle k+1 into result bits [8k+7:8k]. One extra tail cycle (ram_wr=0, ram_a held) captures byte N-1.
  - Write done after N BUSY cycles; read done after N+1. Then go to DONE.
- DONE:
  - Exactly one of if_done/mem_done is high for one cycle.
  - if_data or mem_rdata is updated at entry to DONE and held until that requester's next completion.
  - Requests are ignored in DONE; the requester must drop or renew req. Next state is IDLE.
- if_flush while owner=IF in BUSY: go to IDLE next cycle, no if_done, if_data unchanged. Flush during a MEM transaction or in DONE has no effect.
- Stores are never aborted.
- rdy=0: state, counters and outputs hold, and ram_wr is forced to 0. The sequence resumes at the same k when rdy returns to 1.
- Reset (rst=0 at edge): state IDLE, cnt 0. Outputs: if_data=0, mem_rdata=0, if_done=0, mem_done=0, ram_a=0, ram_wr=0, ram_dout=0. Reset mid-write abandons the remaining bytes.

## Timing
- IDLE outputs: ram_a=0, ram_wr=0, ram_dout=0.
- Req sampled in IDLE at cycle 0 → first RAM address at cycle 1.
- Word fetch: done at cycle 6; byte load: cycle 3; half load: cycle 4.
- Byte store: done at cycle 2; word store: cycle 5.
- Earliest next grant: the cycle after DONE (IDLE at cycle D+1, BUSY at D+2).
- All outputs are registered; no combinational path from req inputs to RAM outputs.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration.
  - When both requests are present in IDLE, the grant goes to the requester that is not last_owner.
  - last_owner resets to IF, so the first contested grant goes to MEM.
- MEM_ARB_RR_EN undefined: fixed MEM-over-IF priority; last_owner is not implemented.

## Test plan
- Word fetch: RAM[0x100..0x103] = 13,05,A0,00; if_req with if_addr=0x100.
  - Expect ram_a = 0x100..0x103 in cycles 1–4.
  - Expect if_done in cycle 6 only, with if_data=0x00A00513.
- Half store then byte load:
  - mem_we=1, size=01, addr=0x2001, wdata=0xDEADBEEF → RAM[0x2001]=EF, RAM[0x2002]=BE, ram_wr high cycles 1–2, mem_done cycle 3.
  - Then load size=00 at 0x2002 → mem_rdata=0x000000BE.
- Contention: mem_req and if_req asserted together in the same cycle.
  - Fixed priority: MEM served first, then IF.
  - Repeat both twice: without MEM_ARB_RR_EN the order is MEM,IF,MEM,IF only because of release timing. With MEM_ARB_RR_EN, the second contested grant goes to IF.
- Flush: if_flush at cycle 3 of a fetch → no if_done, IDLE at cycle 4, if_data unchanged. A pending mem_req is granted at cycle 4.
- rdy low for cycles 2–4 during a word store → ram_wr=0 in those cycles, the byte sequence resumes unchanged, and mem_done is delayed by 3 cycles.
- Reset asserted at cycle 2 of a word store → next cycle all outputs are 0 and the state is IDLE. RAM holds only byte 0.
